// File: rtl/median_frame_loader_pkg.sv
// Shared types and constants for the median frame path.
// data_t is the sample word carried from the stream into the 12-input
// median network; N_WORDS is the network input count and PAD_VALUE fills
// the unused inputs of a short frame.
package median_frame_loader_pkg;

  typedef logic [31:0] data_t;

  localparam int    N_WORDS   = 12;
  localparam data_t PAD_VALUE = 32'hFFFF_FFFF;

  // Loader state: collecting words, or presenting a closed frame.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/median_frame_loader.sv
// Serial-to-parallel frame loader for the 12-input median network.
// Collects streamed words into slots data_0..data_11 in arrival order.
// A frame closes on the 12th word or on in_last, whichever comes first;
// any slot beyond the last real word is filled with PAD_VALUE on the same
// edge. The closed frame is presented with out_valid and held stable until
// the consumer takes it.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_data is the sample,
//                       in_last marks the final word of a frame
//   data_0..data_11     parallel frame to the median network
//   out_valid/out_ready downstream handshake for the whole frame
//   out_count           number of real (non-pad) words, 1..12
module median_frame_loader
  import median_frame_loader_pkg::*;
#(
  parameter int    N_WORDS   = median_frame_loader_pkg::N_WORDS,
  parameter data_t PAD_VALUE = median_frame_loader_pkg::PAD_VALUE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] data_0,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  output logic [31:0] data_3,
  output logic [31:0] data_4,
  output logic [31:0] data_5,
  output logic [31:0] data_6,
  output logic [31:0] data_7,
  output logic [31:0] data_8,
  output logic [31:0] data_9,
  output logic [31:0] data_10,
  output logic [31:0] data_11,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_count
);

  localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  out_count_r, out_count_s;
  logic        out_valid_r, out_valid_s;
  data_t       data_r [N_WORDS];
  data_t       data_s [N_WORDS];
  logic        in_ready_s;
  logic        accept_s;
  logic        handoff_s;
  logic        close_s;

  // Upstream ready: always open while filling; while holding, a new word is
  // taken only on the cycle the held frame leaves, which keeps frames
  // back-to-back without an idle accept cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_FILL: in_ready_s = 1'b1;
        ST_HOLD: in_ready_s = out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  // Next-state, slot write and pad fill. idx is 0 whenever a frame is held,
  // so a word accepted on the handoff edge lands in slot 0 of the next frame
  // through the same write path as any other word.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    out_count_s = out_count_r;
    accept_s    = in_valid && in_ready_s;
    handoff_s   = (state_r == ST_HOLD) && out_ready;
    close_s     = accept_s && (in_last || (idx_r == LAST_IDX));

    for (int j = 0; j < N_WORDS; j++) begin
      if (accept_s && (4'(j) == idx_r)) begin
        data_s[j] = in_data;
      end else if (close_s && (4'(j) > idx_r)) begin
        data_s[j] = PAD_VALUE;
      end else begin
        data_s[j] = data_r[j];
      end
    end

    if (close_s) begin
      out_count_s = idx_r + 4'd1;
      idx_s       = 4'd0;
      state_s     = ST_HOLD;
    end else if (accept_s) begin
      idx_s   = idx_r + 4'd1;
      state_s = ST_FILL;
    end else if (handoff_s) begin
      idx_s   = 4'd0;
      state_s = ST_FILL;
    end else begin
      state_s = state_r;
    end

    out_valid_s = (state_s == ST_HOLD);
  end

  // State, index and frame registers; reset discards any partial or held frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FILL;
      idx_r       <= 4'd0;
      out_count_r <= 4'd0;
      out_valid_r <= 1'b0;
      for (int j = 0; j < N_WORDS; j++) begin
        data_r[j] <= 32'h0;
      end
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      out_count_r <= out_count_s;
      out_valid_r <= out_valid_s;
      for (int j = 0; j < N_WORDS; j++) begin
        data_r[j] <= data_s[j];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_count = out_count_r;
  assign data_0    = data_r[0];
  assign data_1    = data_r[1];
  assign data_2    = data_r[2];
  assign data_3    = data_r[3];
  assign data_4    = data_r[4];
  assign data_5    = data_r[5];
  assign data_6    = data_r[6];
  assign data_7    = data_r[7];
  assign data_8    = data_r[8];
  assign data_9    = data_r[9];
  assign data_10   = data_r[10];
  assign data_11   = data_r[11];

endmodule

// File: tb/tb_median_frame_loader.sv
// Scoreboard bench for median_frame_loader: frames are pushed as expected
// results when generated; a monitor compares whatever frame is presented.
module tb_median_frame_loader;
  import median_frame_loader_pkg::*;

  typedef struct packed {
    logic [11:0][31:0] w;
    logic [3:0]        cnt;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_count;
  logic [31:0] dd [12];

  int     errors = 0;
  int     checks = 0;
  int     or_mode = 0;   // 0: out_ready low, 1: high, 2: random
  frame_t exp_q[$];

  always #5 clk = ~clk;

  median_frame_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .data_0(dd[0]), .data_1(dd[1]), .data_2(dd[2]), .data_3(dd[3]),
    .data_4(dd[4]), .data_5(dd[5]), .data_6(dd[6]), .data_7(dd[7]),
    .data_8(dd[8]), .data_9(dd[9]), .data_10(dd[10]), .data_11(dd[11]),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  function automatic frame_t make_frame(input logic [11:0][31:0] words, input int len);
    frame_t f;
    f.cnt = 4'(len);
    for (int k = 0; k < 12; k++) f.w[k] = (k < len) ? words[k] : PAD_VALUE;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: drives out_ready, then compares any presented frame to the queue head.
  initial begin
    frame_t e;
    int     bad;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(99) < 60);
      endcase
      #2;
      if (!rst) begin
        if (out_valid) begin
          check("in_ready_hold", {31'b0, in_ready}, {31'b0, out_ready});
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got out_valid=1 expected no frame");
          end else begin
            e = exp_q[0];
            check("frame_count", {28'b0, out_count}, {28'b0, e.cnt});
            bad = -1;
            for (int k = 0; k < 12; k++)
              if (dd[k] !== e.w[k] && bad < 0) bad = k;
            checks++;
            if (bad >= 0) begin
              errors++;
              $display("FAIL frame_data slot %0d: got %h expected %h", bad, dd[bad], e.w[bad]);
            end
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          check("in_ready_fill", {31'b0, in_ready}, 32'd1);
        end
      end
    end
  end

  // Offer one word (after optional random idle cycles) until accepted.
  task automatic drive_word(input logic [31:0] w, input logic last, input int idle_pct,
                            output int waits);
    logic acc;
    waits = 0;
    while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom_range(1));
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    forever begin
      #4;
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      waits++;
      if (waits > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept of %h", w);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [11:0][31:0] words, input int len, input int idle_pct,
                            output int total);
    int   w;
    logic last;
    total = 0;
    exp_q.push_back(make_frame(words, len));
    for (int k = 0; k < len; k++) begin
      if (k == len - 1) last = (len == 12) ? 1'($urandom_range(1)) : 1'b1;
      else              last = 1'b0;
      drive_word(words[k], last, idle_pct, w);
      total += w;
    end
  endtask

  task automatic wait_drain();
    or_mode = 1;
    for (int c = 0; c < 600; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [11:0][31:0] words;
    int w, tot;
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_count", {28'b0, out_count}, 32'd0);
    for (int k = 0; k < 12; k++) check("rst_data", dd[k], 32'h0);
    rst = 1'b0;

    // Full frame of 12 words, consumer stalled.
    or_mode = 0;
    for (int k = 0; k < 12; k++) words[k] = 32'(100 + k);
    exp_q.push_back(make_frame(words, 12));
    tot = 0;
    for (int k = 0; k < 12; k++) begin
      check("full_early_valid", {31'b0, out_valid}, 32'd0);
      drive_word(words[k], 1'b0, 0, w);
      tot += w;
    end
    check("full_no_stall", 32'(tot), 32'd0);
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    check("full_out_count", {28'b0, out_count}, 32'd12);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 12; k++) check("full_data", dd[k], 32'(100 + k));

    // Backpressure: next word waits 10 cycles, then becomes slot 0.
    words[0] = 32'd500; words[1] = 32'd501; words[2] = 32'd502;
    exp_q.push_back(make_frame(words, 3));
    in_valid = 1'b1; in_data = 32'd500; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #4;
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_data0_stable", dd[0], 32'd100);
      @(negedge clk);
    end
    or_mode = 1;
    drive_word(32'd500, 1'b0, 0, w);
    drive_word(32'd501, 1'b0, 0, w);
    drive_word(32'd502, 1'b1, 0, w);
    in_valid = 1'b0;
    wait_drain();

    // Short frame 5,9,1 with padding.
    or_mode = 0;
    words[0] = 32'd5; words[1] = 32'd9; words[2] = 32'd1;
    send_frame(words, 3, 0, tot);
    in_valid = 1'b0;
    check("short_out_valid", {31'b0, out_valid}, 32'd1);
    check("short_out_count", {28'b0, out_count}, 32'd3);
    check("short_d0", dd[0], 32'd5);
    check("short_d1", dd[1], 32'd9);
    check("short_d2", dd[2], 32'd1);
    for (int k = 3; k < 12; k++) check("short_pad", dd[k], 32'hFFFF_FFFF);
    wait_drain();

    // Back-to-back: 24 words, consumer always ready.
    or_mode = 1;
    for (int k = 0; k < 12; k++) words[k] = 32'(1000 + k);
    send_frame(words, 12, 0, tot);
    w = tot;
    for (int k = 0; k < 12; k++) words[k] = 32'(1012 + k);
    send_frame(words, 12, 0, tot);
    check("b2b_no_stall", 32'(w + tot), 32'd0);
    in_valid = 1'b0;
    wait_drain();

    // Mid-frame reset after 7 words: partial frame must vanish.
    or_mode = 0;
    for (int k = 0; k < 7; k++) drive_word(32'(7000 + k), 1'b0, 0, w);
    in_valid = 1'b0;
    rst = 1'b1;
    #4;
    check("mrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_out_count", {28'b0, out_count}, 32'd0);
    for (int k = 0; k < 12; k++) check("mrst_data", dd[k], 32'h0);
    words[0] = 32'd9000; words[1] = 32'd9001; words[2] = 32'd9002;
    send_frame(words, 3, 0, tot);
    in_valid = 1'b0;
    check("mrst_next_d0", dd[0], 32'd9000);
    check("mrst_next_count", {28'b0, out_count}, 32'd3);
    wait_drain();

    // Random frames with random idles and consumer backpressure.
    or_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      for (int k = 0; k < 12; k++) words[k] = $urandom;
      send_frame(words, $urandom_range(12, 1), 30, tot);
    end
    in_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_frame_loader.md
MEDIAN_FRAME_LOADER -- requirements
Module: median_frame_loader

Interface
REQ-001 Parameter N_WORDS, default 12: words per frame; SHALL equal the median network input count.
REQ-002 Parameter PAD_VALUE, default 32'hFFFF_FFFF: SHALL be the fill value for unwritten slots of a short frame.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the upstream word is valid.
REQ-006 Port in_ready, output, 1: the loader accepts a word this cycle.
REQ-007 Port in_data, input, 32 (data_t): the streamed sample.
REQ-008 Port in_last, input, 1: qualified by in_valid; marks the final word of a frame.
REQ-009 Ports data_0 .. data_11, output, 32 each (data_t): the parallel frame; drives the 12-input median network directly.
REQ-010 Port out_valid, output, 1: data_0..data_11 and out_count hold a complete frame.
REQ-011 Port out_ready, input, 1: the downstream consumer takes the frame.
REQ-012 Port out_count, output, 4: the number of real (non-pad) words in the presented frame, 1..12.

Function
REQ-013 The block SHALL have two states: FILL (collecting) and HOLD (presenting).
REQ-014 A word SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In HOLD, in_ready SHALL equal out_ready (a combinational path, to give back-to-back frames); out_valid SHALL be 1.
REQ-017 A 4-bit write index idx SHALL start at 0; an accepted word SHALL be written to data_<idx>, then idx SHALL increment.
REQ-018 The frame SHALL close on the accept where idx==N_WORDS-1, or where in_last=1, whichever comes first.
REQ-019 A frame SHALL never exceed 12 words; in_last on the 12th word SHALL be redundant.
REQ-020 On close, all slots with index > idx SHALL load PAD_VALUE on the same edge.
REQ-021 On close, out_count SHALL become idx+1, and the state SHALL become HOLD.
REQ-022 out_valid SHALL rise on the edge of the closing accept, so it is visible the cycle after the final word (latency 1).
REQ-023 In HOLD, data_0..data_11 and out_count SHALL remain stable until out_valid && out_ready.
REQ-024 On the handoff edge (out_valid && out_ready):
- with no simultaneous accept: state->FILL, idx->0, out_valid->0;
- with a simultaneous accept: that word SHALL become slot 0 of the next frame, and idx->1.
REQ-025 A simultaneous handoff plus an accept with in_last=1 SHALL close a 1-word frame:
- slots 1..11 = PAD_VALUE, out_count=1;
- state stays HOLD, out_valid stays 1.
REQ-026 in_last without in_valid SHALL be ignored; in_data is don't-care when not accepted.
REQ-027 The block SHALL NOT drop, duplicate or reorder words; the slot index SHALL equal arrival order within the frame.

Reset
REQ-028 While rst=1, on each clk edge:
- state->FILL, idx->0, out_valid->0, out_count->0;
- data_0..data_11 -> 32'h0.
REQ-029 in_ready SHALL be 0 while rst=1.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or held frame without emitting it.

Structure
REQ-031 data_t (logic [31:0]), N_WORDS and PAD_VALUE SHALL live in a shared package, reused by the median network and its consumers.
REQ-032 No sub-module is needed; one optional wrapper, median_frame_path, SHALL instantiate median_frame_loader feeding median_12_29_7.

Verification
REQ-033 Full frame: after reset, stream 12 words 100..111 with in_valid constant and out_ready=0.
- 12 accepts, then out_valid=1 one cycle later;
- data_k = 100+k, out_count=12, in_ready=0.
REQ-034 Short frame: stream 5,9,1 with in_last on the third word.
- data_0..2 = 5,9,1; data_3..11 = FFFFFFFF; out_count=3.
REQ-035 Back-to-back: hold out_ready=1 and stream 24 words with in_valid constant.
- two frames with no idle accept cycle;
- second frame data_0 = word 12.
REQ-036 Backpressure: frame held 10 cycles with out_ready=0 while in_valid=1.
- outputs stable, no word accepted;
- on out_ready=1 the pending word becomes data_0 of the next frame.
REQ-037 Mid-frame reset: rst=1 for one cycle after 7 words.
- out_valid=0, outputs 0;
- the next frame starts at data_0, and the 7 words never appear.
REQ-038 Random scoreboard: 1000 frames with random lengths 1..12 and random in_valid/out_ready.
- the presented frame matches the reference queue plus padding, with zero mismatches.
